// File: rtl/writeback_unit.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension and register-file write port.
// Optional retired-instruction counter on Instret is built only when WB_RETIRE_COUNT_EN is defined.
module writeback_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Stall,
   input  logic            Flush,
   input  logic            MemValid,
   input  logic            MemRUWr,
   input  logic [4:0]      MemRd,
   input  logic [1:0]      MemRUDataWrSrc,
   input  logic [XLEN-1:0] MemALURes,
   input  logic [XLEN-1:0] MemPCInc,
   input  logic [2:0]      MemDMCtrl,
   input  logic [XLEN-1:0] MemDataRd,
   output logic            RUWr,
   output logic [4:0]      Rd,
   output logic [XLEN-1:0] DataWr,
   output logic            WbValid,
   output logic [63:0]     Instret
);

   logic            valid_q;
   logic            retired_q;
   logic            ruwr_q;
   logic [4:0]      rd_q;
   logic [1:0]      src_q;
   logic [XLEN-1:0] alures_q;
   logic [XLEN-1:0] pcinc_q;
   logic [2:0]      dmctrl_q;
   logic [XLEN-1:0] datard_q;

   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_val;
   logic            retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         retired_q <= 1'b0;
         ruwr_q    <= 1'b0;
         rd_q      <= '0;
         src_q     <= '0;
         alures_q  <= '0;
         pcinc_q   <= '0;
         dmctrl_q  <= '0;
         datard_q  <= '0;
      end else if (Flush) begin
         valid_q   <= 1'b0;
         retired_q <= 1'b0;
      end else if (Stall) begin
         // Once presented, a held entry is marked retired so it never writes twice.
         retired_q <= valid_q;
      end else begin
         valid_q   <= MemValid;
         retired_q <= 1'b0;
         ruwr_q    <= MemRUWr;
         rd_q      <= MemRd;
         src_q     <= MemRUDataWrSrc;
         alures_q  <= MemALURes;
         pcinc_q   <= MemPCInc;
         dmctrl_q  <= MemDMCtrl;
         datard_q  <= MemDataRd;
      end
   end

   always_comb begin
      ld_byte = datard_q[7:0];
      unique case (alures_q[1:0])
         2'd0: ld_byte = datard_q[7:0];
         2'd1: ld_byte = datard_q[15:8];
         2'd2: ld_byte = datard_q[23:16];
         2'd3: ld_byte = datard_q[31:24];
      endcase
      ld_half = alures_q[1] ? datard_q[31:16] : datard_q[15:0];

      // Undefined funct3 codes fall through to a full-word load.
      ld_val = datard_q;
      case (dmctrl_q)
         3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_val = datard_q;
      endcase

      DataWr = '0;
      unique case (src_q)
         2'b00: DataWr = alures_q;
         2'b01: DataWr = ld_val;
         2'b10: DataWr = pcinc_q;
         2'b11: DataWr = '0;
      endcase
   end

   assign retire  = valid_q & ~retired_q;
   assign RUWr    = retire & ruwr_q & (rd_q != 5'd0);
   assign Rd      = rd_q;
   assign WbValid = valid_q;

`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] instret_q;

   // Counts every retiring entry, including ones that do not write a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q <= 64'd0;
      end else if (retire) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign Instret = instret_q;
`else
   assign Instret = 64'd0;
`endif

endmodule
